gpio_port_ctrl: RTL and testbench

Parametrised GPIO port controller; successor to the fixed 8-bit A/B/C ports in soc_top, with one instance per port.
- Provides WIDTH pins with per-pin direction, output data and atomic toggle.
- Synchronises pad inputs and detects edges per pin (rising/falling/both), with sticky W1C pending bits and one aggregated interrupt to the core.
- Pad tri-state is resolved at soc_top; this block exposes separate in/out/oe vectors.

---
 rtl/gpio_pkg.sv | 15 +
 rtl/gpio_sync_filter.sv | 80 ++++++++
 rtl/gpio_port_ctrl.sv | 124 ++++++++++++
 tb/tb_gpio_port_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port controller: register word addresses.
package gpio_pkg;

  typedef logic [2:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_ADDR_DATA_OUT = 3'd0;
  localparam gpio_addr_t GPIO_ADDR_DIR      = 3'd1;
  localparam gpio_addr_t GPIO_ADDR_DATA_IN  = 3'd2;
  localparam gpio_addr_t GPIO_ADDR_IRQ_EN   = 3'd3;
  localparam gpio_addr_t GPIO_ADDR_RISE_EN  = 3'd4;
  localparam gpio_addr_t GPIO_ADDR_FALL_EN  = 3'd5;
  localparam gpio_addr_t GPIO_ADDR_IRQ_PEND = 3'd6;
  localparam gpio_addr_t GPIO_ADDR_TOGGLE   = 3'd7;

endpackage

// File: rtl/gpio_sync_filter.sv
// Two-flop pad synchroniser with optional per-pin debounce (macro GPIO_DEBOUNCE_EN).
// Without the macro DATA_IN is the second sync stage and DB_DIV is unused.
module gpio_sync_filter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DB_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] data_in_o
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = gpio_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DB_DIV);

  logic [DB_W-1:0]        div_q, div_d;
  logic                   tick;
  logic [WIDTH-1:0][1:0]  stab_q, stab_d;
  logic [WIDTH-1:0]       filt_q, filt_d;

  // Prescaler wraps every DB_DIV cycles; a pin follows sync2 after three differing ticks.
  always_comb begin
    tick   = (div_q == DB_W'(DB_DIV - 1));
    div_d  = tick ? '0 : div_q + DB_W'(1);
    stab_d = stab_q;
    filt_d = filt_q;
    if (tick) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (stab_q[i] == 2'd2) begin
            filt_d[i] = sync2_q[i];
            stab_d[i] = 2'd0;
          end else begin
            stab_d[i] = stab_q[i] + 2'd1;
          end
        end else begin
          stab_d[i] = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      stab_q <= '0;
      filt_q <= '0;
    end else begin
      div_q  <= div_d;
      stab_q <= stab_d;
      filt_q <= filt_d;
    end
  end

  assign data_in_o = filt_q;
`else
  logic db_div_unused;
  assign db_div_unused = ^DB_DIV;
  assign data_in_o     = sync2_q;
`endif

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: register file, per-pin edge detection, W1C pending and port IRQ.
// Optional input debounce is enabled with macro GPIO_DEBOUNCE_EN (see gpio_sync_filter).
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DB_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       bus_addr_i,
  input  logic             bus_we_i,
  input  logic             bus_re_i,
  input  logic [WIDTH-1:0] bus_wdata_i,
  output logic [WIDTH-1:0] bus_rdata_o,
  output logic             bus_rvalid_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  gpio_sync_filter #(
    .WIDTH  (WIDTH),
    .DB_DIV (DB_DIV)
  ) u_sync_filter (
    .clk       (clk),
    .rst       (rst),
    .gpio_i    (gpio_i),
    .data_in_o (data_in)
  );

  // Register writes, edge capture (a fresh edge beats a same-cycle clear) and read mux.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    rdata_d    = rdata_q;
    rvalid_d   = bus_re_i;
    w1c_mask   = '0;

    if (bus_we_i) begin
      case (bus_addr_i)
        GPIO_ADDR_DATA_OUT: data_out_d = bus_wdata_i;
        GPIO_ADDR_DIR:      dir_d      = bus_wdata_i;
        GPIO_ADDR_IRQ_EN:   irq_en_d   = bus_wdata_i;
        GPIO_ADDR_RISE_EN:  rise_en_d  = bus_wdata_i;
        GPIO_ADDR_FALL_EN:  fall_en_d  = bus_wdata_i;
        GPIO_ADDR_IRQ_PEND: w1c_mask   = bus_wdata_i;
        GPIO_ADDR_TOGGLE:   data_out_d = data_out_q ^ bus_wdata_i;
        default: ;
      endcase
    end

    rise   = data_in & ~prev_q & rise_en_q & ~dir_q;
    fall   = ~data_in & prev_q & fall_en_q & ~dir_q;
    pend_d = (pend_q & ~w1c_mask) | rise | fall;
    prev_d = data_in;
    irq_d  = |(pend_q & irq_en_q);

    if (bus_re_i) begin
      case (bus_addr_i)
        GPIO_ADDR_DATA_OUT: rdata_d = data_out_q;
        GPIO_ADDR_DIR:      rdata_d = dir_q;
        GPIO_ADDR_DATA_IN:  rdata_d = data_in;
        GPIO_ADDR_IRQ_EN:   rdata_d = irq_en_q;
        GPIO_ADDR_RISE_EN:  rdata_d = rise_en_q;
        GPIO_ADDR_FALL_EN:  rdata_d = fall_en_q;
        GPIO_ADDR_IRQ_PEND: rdata_d = pend_q;
        default:            rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pend_q     <= pend_d;
      prev_q     <= prev_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_o       = data_out_q;
  assign gpio_oe_o    = dir_q;
  assign bus_rdata_o  = rdata_q;
  assign bus_rvalid_o = rvalid_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Self-checking bench for gpio_port_ctrl (default build, no debounce): directed steps
// followed by random bus/pad traffic compared against a behavioural model.
module tb_gpio_port_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] bus_addr_i = '0;
  logic       bus_we_i = 1'b0;
  logic       bus_re_i = 1'b0;
  logic [7:0] bus_wdata_i = '0;
  logic [7:0] bus_rdata_o;
  logic       bus_rvalid_o;
  logic [7:0] gpio_i = '0;
  logic [7:0] gpio_o;
  logic [7:0] gpio_oe_o;
  logic       irq_o;

  int total = 0;
  int bad   = 0;

  gpio_port_ctrl #(.WIDTH(8), .DB_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_addr_i   (bus_addr_i),
    .bus_we_i     (bus_we_i),
    .bus_re_i     (bus_re_i),
    .bus_wdata_i  (bus_wdata_i),
    .bus_rdata_o  (bus_rdata_o),
    .bus_rvalid_o (bus_rvalid_o),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o),
    .gpio_oe_o    (gpio_oe_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  // Model: register values plus the history of pad samples taken at each clock edge.
  logic [7:0] m_dout = '0, m_dir = '0, m_ien = '0, m_ren = '0, m_fen = '0, m_pend = '0;
  logic [7:0] m_rdata = '0;
  logic       m_rvalid = 1'b0, m_irq = 1'b0;
  logic [7:0] samp[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] cur_g = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a, input logic [7:0] din);
    case (a)
      3'd0:    return m_dout;
      3'd1:    return m_dir;
      3'd2:    return din;
      3'd3:    return m_ien;
      3'd4:    return m_ren;
      3'd5:    return m_fen;
      3'd6:    return m_pend;
      default: return 8'h00;
    endcase
  endfunction

  // DATA_IN is the pad value sampled two edges back; prev is one edge older still.
  task automatic model_edge();
    logic [7:0] din, prv, ev, w1c;
    logic       nirq;
    if (rst) begin
      m_dout = '0; m_dir = '0; m_ien = '0; m_ren = '0; m_fen = '0; m_pend = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
      samp = '{8'h00, 8'h00, 8'h00};
    end else begin
      din  = samp[1];
      prv  = samp[2];
      ev   = ((din & ~prv & m_ren) | (~din & prv & m_fen)) & ~m_dir;
      nirq = (m_pend & m_ien) != 8'h00;
      if (bus_re_i) m_rdata = model_read(bus_addr_i, din);
      m_rvalid = bus_re_i;
      w1c = 8'h00;
      if (bus_we_i) begin
        case (bus_addr_i)
          3'd0: m_dout = bus_wdata_i;
          3'd1: m_dir  = bus_wdata_i;
          3'd3: m_ien  = bus_wdata_i;
          3'd4: m_ren  = bus_wdata_i;
          3'd5: m_fen  = bus_wdata_i;
          3'd6: w1c    = bus_wdata_i;
          3'd7: m_dout = m_dout ^ bus_wdata_i;
          default: ;
        endcase
      end
      m_pend = (m_pend & ~w1c) | ev;
      m_irq  = nirq;
      samp.push_front(gpio_i);
      void'(samp.pop_back());
    end
  endtask

  task automatic step(input logic r, input logic we, input logic re, input logic [2:0] a,
                      input logic [7:0] wd);
    rst = r; bus_we_i = we; bus_re_i = re; bus_addr_i = a; bus_wdata_i = wd; gpio_i = cur_g;
    @(posedge clk);
    model_edge();
    #1;
    chk("gpio_o", 32'(gpio_o), 32'(m_dout));
    chk("gpio_oe_o", 32'(gpio_oe_o), 32'(m_dir));
    chk("irq_o", 32'(irq_o), 32'(m_irq));
    chk("rvalid", 32'(bus_rvalid_o), 32'(m_rvalid));
    chk("rdata", 32'(bus_rdata_o), 32'(m_rdata));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, 1'b0, 1'b1, a, 8'h00);
  endtask

  initial begin
    // Reset defaults
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    idle(1);
    for (int a = 0; a < 7; a++) begin
      rd(3'(a));
      chk("rst_read_data", 32'(bus_rdata_o), 32'h0);
      chk("rst_read_valid", 32'(bus_rvalid_o), 32'h1);
    end
    chk("rst_oe", 32'(gpio_oe_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);

    // Output and toggle
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'hA5);
    chk("out_a5", 32'(gpio_o), 32'hA5);
    wr(3'd7, 8'h0F);
    chk("toggle_aa", 32'(gpio_o), 32'hAA);
    rd(3'd0);
    chk("read_dout_aa", 32'(bus_rdata_o), 32'hAA);
    rd(3'd7);
    chk("read_toggle_zero", 32'(bus_rdata_o), 32'h0);

    // Input latency
    wr(3'd1, 8'h00);
    cur_g = 8'h3C;
    idle(2);
    rd(3'd2);
    chk("data_in_3c", 32'(bus_rdata_o), 32'h3C);
    wr(3'd2, 8'hFF);
    rd(3'd2);
    chk("data_in_ro", 32'(bus_rdata_o), 32'h3C);

    // Edge interrupt
    cur_g = 8'h80;
    wr(3'd4, 8'h01);
    wr(3'd5, 8'h80);
    wr(3'd3, 8'h81);
    idle(4);
    wr(3'd6, 8'hFF);
    idle(2);
    cur_g = 8'h81;
    idle(3);
    chk("irq_before_k3", 32'(irq_o), 32'h0);
    rd(3'd6);
    chk("pend_rise", 32'(bus_rdata_o), 32'h01);
    chk("irq_at_k3", 32'(irq_o), 32'h1);
    cur_g = 8'h01;
    idle(4);
    rd(3'd6);
    chk("pend_fall", 32'(bus_rdata_o), 32'h81);
    wr(3'd6, 8'h01);
    rd(3'd6);
    chk("pend_w1c", 32'(bus_rdata_o), 32'h80);
    chk("irq_still_set", 32'(irq_o), 32'h1);

    // Collision of W1C with a new edge, then masking by DIR
    cur_g = 8'h00;
    idle(4);
    cur_g = 8'h01;
    idle(2);
    wr(3'd6, 8'h01);
    rd(3'd6);
    chk("pend_collision", 32'(bus_rdata_o), 32'h81);
    wr(3'd1, 8'h01);
    wr(3'd6, 8'hFF);
    cur_g = 8'h00;
    idle(4);
    cur_g = 8'h01;
    idle(4);
    rd(3'd6);
    chk("pend_dir_masked", 32'(bus_rdata_o), 32'h00);
    idle(2);
    chk("irq_cleared", 32'(irq_o), 32'h0);

    // Random traffic
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    wr(3'd4, 8'hFF);
    wr(3'd5, 8'hFF);
    wr(3'd3, 8'($urandom));
    for (int n = 0; n < 600; n++) begin
      logic       r;
      int unsigned op;
      r  = ($urandom_range(0, 99) == 0);
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) cur_g = 8'($urandom);
      case (op)
        1:       step(r, 1'b1, 1'b0, 3'($urandom), 8'($urandom));
        2, 3:    step(r, 1'b0, 1'b1, 3'($urandom), 8'h00);
        default: step(r, 1'b0, 1'b0, 3'd0, 8'h00);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
